// File: rtl/rp_shutdown_pkg.sv
// rp_shutdown_pkg: shared state encoding and width helpers for the RP shutdown sequencer
package rp_shutdown_pkg;
  typedef enum logic [2:0] {ACTIVE, DRAIN, REQ, DECOUPLED, RELEASE, WAKE} state_t;
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction
  function automatic int tmr_w(input int timeout, input int hold);
    return $clog2((timeout > hold ? timeout : hold) + 1);
  endfunction
endpackage

// File: rtl/rp_outstanding_cnt.sv
// rp_outstanding_cnt: saturating outstanding-burst counter, simultaneous inc/dec cancel
module rp_outstanding_cnt
  import rp_shutdown_pkg::*;
#(
  parameter int MAX = 16,
  parameter int W   = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         empty
);
  assign full  = cnt >= W'(MAX);
  assign empty = cnt == '0;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc && !dec && !full) cnt <= cnt + 1'b1;
    else if (dec && !inc && !empty) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/rp_shutdown_ctrl.sv
// rp_shutdown_ctrl: drains PCIe AXI traffic, shuts down, decouples and re-wakes a reconfigurable partition
module rp_shutdown_ctrl
  import rp_shutdown_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 65536,
  parameter int MAX_OUTSTANDING = 16,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pr_shutdown_req,
  output logic pr_shutdown_ack,
  input  logic pr_reconfig_done,
  output logic timeout_err,
  output logic shutdown_req,
  input  logic shutdown_ack,
  input  logic active,
  output logic decouple,
  output logic rst_prc_n,
  input  logic s_arvalid,
  output logic s_arready,
  input  logic s_awvalid,
  output logic s_awready,
  output logic m_arvalid,
  input  logic m_arready,
  output logic m_awvalid,
  input  logic m_awready,
  input  logic rvalid,
  input  logic rready,
  input  logic rlast,
  input  logic bvalid,
  input  logic bready
);
  localparam int CW = cnt_w(MAX_OUTSTANDING);
  localparam int TW = tmr_w(TIMEOUT_CYCLES, RST_HOLD_CYCLES);
  state_t        state;
  logic [TW-1:0] tmr;
  logic [CW-1:0] rd_cnt, wr_cnt;
  logic          rd_full, rd_empty, wr_full, wr_empty;
  logic          open_rd, open_wr, tmo, hold_done, to_dec;
  assign open_rd   = (state == ACTIVE) && !rd_full;
  assign open_wr   = (state == ACTIVE) && !wr_full;
  assign m_arvalid = s_arvalid & open_rd;
  assign s_arready = m_arready & open_rd;
  assign m_awvalid = s_awvalid & open_wr;
  assign s_awready = m_awready & open_wr;
  assign tmo       = tmr == TW'(TIMEOUT_CYCLES - 1);
  assign hold_done = tmr == TW'(RST_HOLD_CYCLES - 1);
  assign to_dec    = (state == REQ) && (shutdown_ack || tmo);
  rp_outstanding_cnt #(.MAX(MAX_OUTSTANDING), .W(CW)) u_rd_cnt (
    .clk(clk), .rst(rst), .clr(to_dec),
    .inc(m_arvalid & m_arready), .dec(rvalid & rready & rlast),
    .cnt(rd_cnt), .full(rd_full), .empty(rd_empty)
  );
  rp_outstanding_cnt #(.MAX(MAX_OUTSTANDING), .W(CW)) u_wr_cnt (
    .clk(clk), .rst(rst), .clr(to_dec),
    .inc(m_awvalid & m_awready), .dec(bvalid & bready),
    .cnt(wr_cnt), .full(wr_full), .empty(wr_empty)
  );
  // tmr free-runs and is zeroed on every transition; only DRAIN/REQ/RELEASE/WAKE look at it
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RELEASE;
      tmr             <= '0;
      decouple        <= 1'b1;
      rst_prc_n       <= 1'b0;
      shutdown_req    <= 1'b0;
      pr_shutdown_ack <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      tmr <= tmr + 1'b1;
      case (state)
        ACTIVE: if (pr_shutdown_req) begin
          state <= DRAIN;
          tmr   <= '0;
        end
        DRAIN: if ((rd_empty && wr_empty) || tmo) begin
          state        <= REQ;
          tmr          <= '0;
          shutdown_req <= 1'b1;
          timeout_err  <= timeout_err | (|{rd_cnt, wr_cnt});
        end
        REQ: if (to_dec) begin
          state           <= DECOUPLED;
          tmr             <= '0;
          shutdown_req    <= 1'b0;
          decouple        <= 1'b1;
          rst_prc_n       <= 1'b0;
          pr_shutdown_ack <= 1'b1;
          timeout_err     <= timeout_err | !shutdown_ack;
        end
        DECOUPLED: if (pr_reconfig_done && !pr_shutdown_req) begin
          state           <= RELEASE;
          tmr             <= '0;
          pr_shutdown_ack <= 1'b0;
        end
        RELEASE: if (hold_done) begin
          state     <= WAKE;
          tmr       <= '0;
          rst_prc_n <= 1'b1;
        end
        WAKE: if (active || tmo) begin
          state       <= ACTIVE;
          tmr         <= '0;
          decouple    <= 1'b0;
          timeout_err <= timeout_err | !active;
        end
        default: begin
          state <= RELEASE;
          tmr   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rp_shutdown_ctrl.sv
// tb_rp_shutdown_ctrl: directed scenario tests for the RP shutdown sequencer
module tb_rp_shutdown_ctrl;
  logic clk = 0, rst = 1;
  logic pr_shutdown_req = 0, pr_reconfig_done = 0, shutdown_ack = 0, active = 0;
  logic s_arvalid = 0, m_arready = 1, s_awvalid = 0, m_awready = 1;
  logic rvalid = 0, rready = 1, rlast = 0, bvalid = 0, bready = 1;
  logic pr_shutdown_ack, timeout_err, shutdown_req, decouple, rst_prc_n;
  logic s_arready, s_awready, m_arvalid, m_awvalid;
  int errors = 0, checks = 0;
  rp_shutdown_ctrl #(.TIMEOUT_CYCLES(32), .MAX_OUTSTANDING(4), .RST_HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .pr_shutdown_req(pr_shutdown_req), .pr_shutdown_ack(pr_shutdown_ack),
    .pr_reconfig_done(pr_reconfig_done), .timeout_err(timeout_err),
    .shutdown_req(shutdown_req), .shutdown_ack(shutdown_ack), .active(active),
    .decouple(decouple), .rst_prc_n(rst_prc_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .bvalid(bvalid), .bready(bready)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1;
    tick();
    tick();
    checks++;
    if ({decouple, rst_prc_n, shutdown_req, pr_shutdown_ack, timeout_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=10000", {decouple, rst_prc_n, shutdown_req, pr_shutdown_ack, timeout_err});
    end
    s_arvalid = 1;
    s_awvalid = 1;
    #1;
    checks++;
    if ({s_arready, m_arvalid, s_awready, m_awvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gates got=%b exp=0000", {s_arready, m_arvalid, s_awready, m_awvalid});
    end
    s_arvalid = 0;
    s_awvalid = 0;
    rst = 0;
    repeat (3) tick();
    checks++;
    if (rst_prc_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=0", rst_prc_n);
    end
    tick();
    checks++;
    if ({rst_prc_n, decouple} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release got=%b exp=11", {rst_prc_n, decouple});
    end
    repeat (4) tick();
    checks++;
    if (decouple !== 1'b1) begin
      errors++;
      $display("FAIL wake_wait_decouple got=%b exp=1", decouple);
    end
    active = 1;
    tick();
    checks++;
    if ({decouple, timeout_err} !== 2'b00) begin
      errors++;
      $display("FAIL wake_active got=%b exp=00", {decouple, timeout_err});
    end
  endtask
  task automatic test_drain;
    for (int i = 0; i < 3; i++) begin
      s_arvalid = 1;
      #1;
      checks++;
      if ({s_arready, m_arvalid} !== 2'b11) begin
        errors++;
        $display("FAIL ar_accept%0d got=%b exp=11", i, {s_arready, m_arvalid});
      end
      tick();
    end
    s_arvalid = 0;
    pr_shutdown_req = 1;
    tick();
    s_arvalid = 1;
    #1;
    checks++;
    if ({s_arready, m_arvalid} !== 2'b00) begin
      errors++;
      $display("FAIL drain_gated got=%b exp=00", {s_arready, m_arvalid});
    end
    for (int i = 0; i < 3; i++) begin
      rvalid = 1;
      rlast = 1;
      tick();
      rvalid = 0;
      rlast = 0;
      checks++;
      if (shutdown_req !== 1'b0) begin
        errors++;
        $display("FAIL drain_rlast%0d got=%b exp=0", i, shutdown_req);
      end
      tick();
      checks++;
      if (shutdown_req !== (i == 2)) begin
        errors++;
        $display("FAIL drain_req%0d got=%b exp=%b", i, shutdown_req, i == 2);
      end
    end
    s_arvalid = 0;
  endtask
  task automatic test_req_timeout;
    repeat (31) tick();
    checks++;
    if ({pr_shutdown_ack, shutdown_req, timeout_err} !== 3'b010) begin
      errors++;
      $display("FAIL req_wait got=%b exp=010", {pr_shutdown_ack, shutdown_req, timeout_err});
    end
    tick();
    checks++;
    if ({pr_shutdown_ack, shutdown_req, timeout_err, rst_prc_n, decouple} !== 5'b10101) begin
      errors++;
      $display("FAIL req_timeout got=%b exp=10101", {pr_shutdown_ack, shutdown_req, timeout_err, rst_prc_n, decouple});
    end
  endtask
  task automatic test_reconfig;
    shutdown_ack = 1;
    pr_reconfig_done = 1;
    tick();
    pr_reconfig_done = 0;
    tick();
    checks++;
    if ({pr_shutdown_ack, rst_prc_n} !== 2'b10) begin
      errors++;
      $display("FAIL done_dropped got=%b exp=10", {pr_shutdown_ack, rst_prc_n});
    end
    shutdown_ack = 0;
    pr_shutdown_req = 0;
    tick();
    pr_reconfig_done = 1;
    tick();
    pr_reconfig_done = 0;
    checks++;
    if ({pr_shutdown_ack, rst_prc_n, decouple} !== 3'b001) begin
      errors++;
      $display("FAIL release_entry got=%b exp=001", {pr_shutdown_ack, rst_prc_n, decouple});
    end
    repeat (3) tick();
    checks++;
    if (rst_prc_n !== 1'b0) begin
      errors++;
      $display("FAIL release_hold got=%b exp=0", rst_prc_n);
    end
    tick();
    checks++;
    if ({rst_prc_n, decouple} !== 2'b11) begin
      errors++;
      $display("FAIL release_wake got=%b exp=11", {rst_prc_n, decouple});
    end
    tick();
    checks++;
    if ({decouple, timeout_err} !== 2'b01) begin
      errors++;
      $display("FAIL reactive_sticky got=%b exp=01", {decouple, timeout_err});
    end
  endtask
  task automatic test_aw_limit;
    for (int i = 0; i < 4; i++) begin
      s_awvalid = 1;
      #1;
      checks++;
      if ({s_awready, m_awvalid} !== 2'b11) begin
        errors++;
        $display("FAIL aw_accept%0d got=%b exp=11", i, {s_awready, m_awvalid});
      end
      tick();
    end
    checks++;
    if ({s_awready, m_awvalid} !== 2'b00) begin
      errors++;
      $display("FAIL aw_full got=%b exp=00", {s_awready, m_awvalid});
    end
    bvalid = 1;
    tick();
    checks++;
    if (s_awready !== 1'b1) begin
      errors++;
      $display("FAIL aw_after_b got=%b exp=1", s_awready);
    end
    tick();
    bvalid = 0;
    #1;
    checks++;
    if (s_awready !== 1'b1) begin
      errors++;
      $display("FAIL aw_b_same_cycle got=%b exp=1", s_awready);
    end
    tick();
    checks++;
    if (s_awready !== 1'b0) begin
      errors++;
      $display("FAIL aw_refull got=%b exp=0", s_awready);
    end
    s_awvalid = 0;
  endtask
  task automatic test_rst_mid;
    for (int i = 0; i < 2; i++) begin
      s_arvalid = 1;
      tick();
    end
    s_arvalid = 0;
    pr_shutdown_req = 1;
    tick();
    tick();
    checks++;
    if ({decouple, shutdown_req, rst_prc_n} !== 3'b001) begin
      errors++;
      $display("FAIL mid_drain got=%b exp=001", {decouple, shutdown_req, rst_prc_n});
    end
    rst = 1;
    tick();
    s_arvalid = 1;
    s_awvalid = 1;
    #1;
    checks++;
    if ({decouple, rst_prc_n, s_arready, m_arvalid, s_awready, m_awvalid} !== 6'b100000) begin
      errors++;
      $display("FAIL mid_rst got=%b exp=100000", {decouple, rst_prc_n, s_arready, m_arvalid, s_awready, m_awvalid});
    end
    s_arvalid = 0;
    s_awvalid = 0;
    rst = 0;
    pr_shutdown_req = 0;
    repeat (4) tick();
    checks++;
    if ({rst_prc_n, timeout_err} !== 2'b10) begin
      errors++;
      $display("FAIL mid_rewake got=%b exp=10", {rst_prc_n, timeout_err});
    end
    tick();
    checks++;
    if (decouple !== 1'b0) begin
      errors++;
      $display("FAIL mid_active got=%b exp=0", decouple);
    end
    for (int i = 0; i < 4; i++) begin
      s_arvalid = 1;
      s_awvalid = 1;
      #1;
      checks++;
      if ({s_arready, s_awready} !== 2'b11) begin
        errors++;
        $display("FAIL cnt_cleared%0d got=%b exp=11", i, {s_arready, s_awready});
      end
      tick();
    end
    checks++;
    if ({s_arready, s_awready} !== 2'b00) begin
      errors++;
      $display("FAIL cnt_refull got=%b exp=00", {s_arready, s_awready});
    end
    s_arvalid = 0;
    s_awvalid = 0;
  endtask
  initial begin
    test_reset();
    test_drain();
    test_req_timeout();
    test_reconfig();
    test_aw_limit();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
